gemclct_best_sort: RTL and testbench

Parametrised, pipelined successor to the GEM-CLCT bending-angle sorter. It selects, from NCH GEM-CLCT match candidates, the one with the smallest bending-angle priority among those flagged by the ALCT-CLCT-GEM match vector. It returns that candidate's index, priority and GEM x-key. It sits in the TMB GEM-CSC matching path between the per-window match logic and the LCT builder, and registers one tree level per clock.

---
 rtl/gemclct_best_sort_if.sv | 31 +++
 rtl/gemclct_best_sort.sv | 119 +++++++++++
 tb/tb_gemclct_best_sort.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemclct_best_sort_if.sv
// Candidate/result bundle for the GEM-CLCT best-candidate sorter.
// The master drives candidate sets and the slave returns the winner.
interface gemclct_best_sort_if #(
   parameter int NCH  = 8,
   parameter int PRIW = 10,
   parameter int XKYW = 10
);
   localparam int LEVELS = $clog2(NCH);

   logic                 in_valid;
   logic [NCH-1:0]       match_vpf;
   logic [NCH*PRIW-1:0]  win_pri;
   logic [NCH*XKYW-1:0]  gem_xky;

   logic                 out_valid;
   logic                 out_found;
   logic [LEVELS-1:0]    win_best;
   logic [PRIW-1:0]      pri_best;
   logic [XKYW-1:0]      gem_xky_best;
   logic [15:0]          found_count;

   modport master (
      output in_valid, match_vpf, win_pri, gem_xky,
      input  out_valid, out_found, win_best, pri_best, gem_xky_best, found_count
   );

   modport slave (
      input  in_valid, match_vpf, win_pri, gem_xky,
      output out_valid, out_found, win_best, pri_best, gem_xky_best, found_count
   );
endinterface

// File: rtl/gemclct_best_sort.sv
// Pipelined binary-tree sorter: picks the matched candidate with the smallest priority, one tree level per clock.
// Optional GEMCLCT_SORT_VETO_EN: an all-ones priority ("no GEM in window") forces that leaf invalid.
module gemclct_best_sort #(
   parameter int NCH  = 8,
   parameter int PRIW = 10,
   parameter int XKYW = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   gemclct_best_sort_if.slave   bus
);
   localparam int LEVELS = $clog2(NCH);
   localparam int NN     = NCH - 1;

   logic              leaf_vld [NCH];
   logic [PRIW-1:0]   leaf_pri [NCH];
   logic [XKYW-1:0]   leaf_xky [NCH];

   // Heap layout: node 1 is the root, children of node n are 2n and 2n+1;
   // children at or above NCH are leaves.
   logic              node_vld [1:NN];
   logic [PRIW-1:0]   node_pri [1:NN];
   logic [XKYW-1:0]   node_xky [1:NN];
   logic [LEVELS-1:0] node_idx [1:NN];

   logic              nxt_vld  [1:NN];
   logic [PRIW-1:0]   nxt_pri  [1:NN];
   logic [XKYW-1:0]   nxt_xky  [1:NN];
   logic [LEVELS-1:0] nxt_idx  [1:NN];

   logic [LEVELS-1:0] vpipe_q;
   logic [LEVELS-1:0] vpipe_d;
   logic [15:0]       cnt_q;
   logic              found;

   function automatic logic [LEVELS-1:0] level_bit(input int n);
      int d;
      logic [LEVELS-1:0] r;
      d = 0;
      for (int k = 1; k < LEVELS; k++) begin
         if (n >= (1 << k)) d = k;
      end
      r = '0;
      r[LEVELS-1-d] = 1'b1;
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         leaf_pri[i] = bus.win_pri[i*PRIW +: PRIW];
         leaf_xky[i] = bus.gem_xky[i*XKYW +: XKYW];
`ifdef GEMCLCT_SORT_VETO_EN
         leaf_vld[i] = bus.match_vpf[i] && (leaf_pri[i] != {PRIW{1'b1}});
`else
         leaf_vld[i] = bus.match_vpf[i];
`endif
      end
   end

   always_comb begin
      logic              a_v, b_v, pb;
      logic [PRIW-1:0]   a_p, b_p;
      logic [XKYW-1:0]   a_x, b_x;
      logic [LEVELS-1:0] a_i, b_i;
      int                li, ni;
      for (int n = 1; n <= NN; n++) begin
         li = (2*n >= NCH) ? (2*n - NCH) : 0;
         ni = (2*n <  NCH) ? (2*n) : 1;
         if (2*n >= NCH) begin
            a_v = leaf_vld[li];   b_v = leaf_vld[li+1];
            a_p = leaf_pri[li];   b_p = leaf_pri[li+1];
            a_x = leaf_xky[li];   b_x = leaf_xky[li+1];
            a_i = '0;             b_i = '0;
         end else begin
            a_v = node_vld[ni];   b_v = node_vld[ni+1];
            a_p = node_pri[ni];   b_p = node_pri[ni+1];
            a_x = node_xky[ni];   b_x = node_xky[ni+1];
            a_i = node_idx[ni];   b_i = node_idx[ni+1];
         end
         // Strict less-than keeps ties on the lower-index side.
         pb = b_v && (!a_v || (b_p < a_p));
         nxt_vld[n] = a_v | b_v;
         nxt_pri[n] = pb ? b_p : a_p;
         nxt_xky[n] = pb ? b_x : a_x;
         nxt_idx[n] = pb ? (b_i | level_bit(n)) : a_i;
      end
   end

   always_comb begin
      vpipe_d[0] = bus.in_valid;
      for (int i = 1; i < LEVELS; i++) vpipe_d[i] = vpipe_q[i-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vpipe_q <= '0;
         cnt_q   <= '0;
         for (int n = 1; n <= NN; n++) node_vld[n] <= 1'b0;
      end else begin
         vpipe_q  <= vpipe_d;
         node_vld <= nxt_vld;
         if (vpipe_d[LEVELS-1] && nxt_vld[1] && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      node_pri <= nxt_pri;
      node_xky <= nxt_xky;
      node_idx <= nxt_idx;
   end

   assign found            = vpipe_q[LEVELS-1] && node_vld[1];
   assign bus.out_valid    = vpipe_q[LEVELS-1];
   assign bus.out_found    = found;
   assign bus.win_best     = found ? node_idx[1] : '0;
   assign bus.pri_best     = found ? node_pri[1] : {PRIW{1'b1}};
   assign bus.gem_xky_best = found ? node_xky[1] : '0;
   assign bus.found_count  = cnt_q;
endmodule

// File: tb/tb_gemclct_best_sort.sv
// Self-checking bench for gemclct_best_sort: a linear-scan reference model with a
// latency queue is compared every cycle, plus hand-computed scenario checks.
module tb_gemclct_best_sort;
   localparam int NCH    = 8;
   localparam int PRIW   = 10;
   localparam int XKYW   = 10;
   localparam int LEVELS = $clog2(NCH);

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   gemclct_best_sort_if #(.NCH(NCH), .PRIW(PRIW), .XKYW(XKYW)) bus ();

   gemclct_best_sort #(.NCH(NCH), .PRIW(PRIW), .XKYW(XKYW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic              v;
      logic              f;
      logic [LEVELS-1:0] idx;
      logic [PRIW-1:0]   pri;
      logic [XKYW-1:0]   xky;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   res_t pipe [LEVELS];
   res_t e;
   logic [15:0] m_cnt = 16'd0;
   bit   armed = 1'b0;

   function automatic res_t no_result(input logic v);
      res_t r;
      r.v = v; r.f = 1'b0; r.idx = '0; r.pri = {PRIW{1'b1}}; r.xky = '0;
      return r;
   endfunction

   // Winner = lowest index among eligible candidates holding the minimum priority.
   function automatic res_t model(input logic iv, input logic [NCH-1:0] vpf,
                                  input logic [NCH*PRIW-1:0] pri, input logic [NCH*XKYW-1:0] xky);
      res_t r;
      int best;
      logic [PRIW-1:0] p, bp;
      bit ok;
      r = no_result(iv);
      best = -1;
      bp = '1;
      for (int i = 0; i < NCH; i++) begin
         p  = pri[i*PRIW +: PRIW];
         ok = vpf[i];
`ifdef GEMCLCT_SORT_VETO_EN
         if (p == {PRIW{1'b1}}) ok = 1'b0;
`endif
         if (ok && (best < 0 || p < bp)) begin
            best = i;
            bp = p;
         end
      end
      if (iv && best >= 0) begin
         r.f   = 1'b1;
         r.idx = LEVELS'(best);
         r.pri = bp;
         r.xky = xky[best*XKYW +: XKYW];
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LEVELS; i++) pipe[i] = no_result(1'b0);
         m_cnt = 16'd0;
         armed = 1'b1;
      end else begin
         for (int i = LEVELS-1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = model(bus.in_valid, bus.match_vpf, bus.win_pri, bus.gem_xky);
         if (pipe[LEVELS-1].v && pipe[LEVELS-1].f && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      e = pipe[LEVELS-1];
   end

   always @(negedge clock) begin
      if (armed) begin
         chk("cyc_out_valid",   32'(bus.out_valid),    32'(e.v));
         chk("cyc_out_found",   32'(bus.out_found),    32'(e.f));
         chk("cyc_win_best",    32'(bus.win_best),     32'(e.idx));
         chk("cyc_pri_best",    32'(bus.pri_best),     32'(e.pri));
         chk("cyc_gem_xky",     32'(bus.gem_xky_best), 32'(e.xky));
         chk("cyc_found_count", 32'(bus.found_count),  32'(m_cnt));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   logic [NCH-1:0]      vpf;
   logic [NCH*PRIW-1:0] pv;
   logic [NCH*XKYW-1:0] xv;

   task automatic drive(input logic iv);
      bus.in_valid  = iv;
      bus.match_vpf = vpf;
      bus.win_pri   = pv;
      bus.gem_xky   = xv;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic fill_pri(input int v);
      for (int i = 0; i < NCH; i++) pv[i*PRIW +: PRIW] = PRIW'(v);
   endtask

   task automatic rand_xky();
      for (int i = 0; i < NCH; i++) xv[i*XKYW +: XKYW] = XKYW'($urandom);
   endtask

   initial begin
      int tp [NCH];
      int need;
      tp = '{5, 10, 20, 30, 40, 50, 60, 70};
      vpf = '0; pv = '0; xv = '0;
      bus.in_valid = 1'b0; bus.match_vpf = '0; bus.win_pri = '0; bus.gem_xky = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Reset / latency
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_pri_best",  32'(bus.pri_best),  32'h3FF);
      chk("rst_count",     32'(bus.found_count), 32'd0);
      vpf = 8'hFF;
      for (int i = 0; i < NCH; i++) pv[i*PRIW +: PRIW] = PRIW'(tp[i]);
      rand_xky();
      drive(1'b1);
      idle(LEVELS-2);
      chk("lat_early_valid", 32'(bus.out_valid), 32'd0);
      idle(1);
      chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_win_best",  32'(bus.win_best), 32'd0);
      chk("lat_pri_best",  32'(bus.pri_best), 32'd5);
      chk("lat_count",     32'(bus.found_count), 32'd1);

      // Masking
      vpf = 8'b1000_0100; fill_pri(0);
      pv[7*PRIW +: PRIW] = 10'd12; pv[2*PRIW +: PRIW] = 10'd30;
      rand_xky(); xv[7*XKYW +: XKYW] = 10'h155;
      drive(1'b1); idle(LEVELS-1);
      chk("mask_win",  32'(bus.win_best), 32'd7);
      chk("mask_pri",  32'(bus.pri_best), 32'd12);
      chk("mask_xky",  32'(bus.gem_xky_best), 32'h155);

      // Tie break and empty set
      vpf = 8'hFF; fill_pri(9);
      pv[3*PRIW +: PRIW] = 10'd4; pv[6*PRIW +: PRIW] = 10'd4;
      drive(1'b1); idle(LEVELS-1);
      chk("tie_win",   32'(bus.win_best), 32'd3);
      chk("tie_pri",   32'(bus.pri_best), 32'd4);
      chk("tie_count", 32'(bus.found_count), 32'd3);
      vpf = 8'h00;
      drive(1'b1); idle(LEVELS-1);
      chk("none_valid", 32'(bus.out_valid), 32'd1);
      chk("none_found", 32'(bus.out_found), 32'd0);
      chk("none_pri",   32'(bus.pri_best), 32'h3FF);
      chk("none_win",   32'(bus.win_best), 32'd0);
      chk("none_count", 32'(bus.found_count), 32'd3);

      // Veto behaviour
      vpf = 8'h03; fill_pri(100);
      pv[0 +: PRIW] = 10'h3FF; pv[PRIW +: PRIW] = 10'h3FF;
      drive(1'b1); idle(LEVELS-1);
`ifdef GEMCLCT_SORT_VETO_EN
      chk("veto_found", 32'(bus.out_found), 32'd0);
`else
      chk("veto_found", 32'(bus.out_found), 32'd1);
      chk("veto_win",   32'(bus.win_best), 32'd0);
`endif

      // Streaming: back-to-back winners 1..5
      fork
         begin
            for (int k = 1; k <= 5; k++) begin
               vpf = 8'hFF; fill_pri(50);
               pv[k*PRIW +: PRIW] = PRIW'(k);
               drive(1'b1);
            end
            bus.in_valid = 1'b0;
         end
         begin
            repeat (LEVELS) @(posedge clock);
            #1;
            for (int k = 1; k <= 5; k++) begin
               chk("stream_valid", 32'(bus.out_valid), 32'd1);
               chk("stream_win",   32'(bus.win_best), 32'(k));
               @(posedge clock);
               #1;
            end
         end
      join
      idle(2);

      // Reset mid-stream discards everything in flight
      vpf = 8'hFF; fill_pri(50); pv[2*PRIW +: PRIW] = 10'd1;
      drive(1'b1);
      drive(1'b1);
      reset = 1'b1;
      drive(1'b1);
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
      for (int k = 0; k < LEVELS + 2; k++) begin
         chk("rstmid_no_valid", 32'(bus.out_valid), 32'd0);
         chk("rstmid_count",    32'(bus.found_count), 32'd0);
         idle(1);
      end
      pv[6*PRIW +: PRIW] = 10'd0;
      drive(1'b1); idle(LEVELS-2);
      chk("rstmid_early", 32'(bus.out_valid), 32'd0);
      idle(1);
      chk("rstmid_first_valid", 32'(bus.out_valid), 32'd1);
      chk("rstmid_first_win",   32'(bus.win_best), 32'd6);
      chk("rstmid_first_count", 32'(bus.found_count), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         vpf = ($urandom_range(7) == 0) ? '0 : NCH'($urandom);
         for (int i = 0; i < NCH; i++) begin
            case ($urandom_range(3))
               0:       pv[i*PRIW +: PRIW] = PRIW'($urandom_range(3));
               1:       pv[i*PRIW +: PRIW] = {PRIW{1'b1}};
               default: pv[i*PRIW +: PRIW] = PRIW'($urandom);
            endcase
         end
         rand_xky();
         drive(($urandom_range(3) != 0));
      end
      idle(LEVELS + 1);

      // Saturation of found_count
      need = 32'hFFFE - int'(m_cnt);
      vpf = 8'h01; fill_pri(0);
      for (int n = 0; n < need; n++) drive(1'b1);
      idle(LEVELS);
      chk("sat_fffe", 32'(bus.found_count), 32'hFFFE);
      for (int n = 0; n < 3; n++) drive(1'b1);
      idle(LEVELS);
      chk("sat_ffff", 32'(bus.found_count), 32'hFFFF);
      drive(1'b1); idle(LEVELS);
      chk("sat_hold", 32'(bus.found_count), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
